// File: rtl/cr_kme_fifo_unpack_pkg.sv
// KME staging FIFO unpacker: shared types and constants.
// Beat/word geometry and the word-count sideband decoder.
package cr_kme_fifo_unpack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int KME_BEAT_W = 128;
  localparam int KME_WORD_W = 32;
  localparam int KME_RATIO  = 4;

  // A zero count means a full beat.
  function automatic logic [2:0] nwords_decode(
    input logic [1:0] n
  );
    return (n == 2'd0) ? 3'd4 : {1'b0, n};
  endfunction

endpackage

// File: rtl/cr_kme_sticky_err.sv
// Sticky error flag with set priority over clear.
// Holds a one-cycle pulse until software clears it.
module cr_kme_sticky_err (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Set wins when set and clear coincide.
  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end

endmodule

// File: rtl/cr_kme_fifo_unpack.sv
// KME FIFO read-side unpacker: 128-bit beats to 32-bit words.
// Pops on ack, drains with valid/ready, tracks sticky errors.
module cr_kme_fifo_unpack
  import cr_kme_fifo_unpack_pkg::*;
#(
  parameter int IN_W      = KME_BEAT_W,
  parameter int OUT_W     = KME_WORD_W,
  parameter int RATIO     = IN_W / OUT_W,
  parameter int LSW_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic [1:0]       in_nwords,
  output logic             in_ack,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             fifo_overflow,
  input  logic             fifo_underflow,
  input  logic             err_clr,
  output logic             err_ovf,
  output logic             err_udf,
  output logic [15:0]      beats_popped
);

  state_e          st;
  logic [IN_W-1:0] hold;
  logic [1:0]      idx;
  logic [2:0]      nwords_q;
  logic            hs;
  logic            take;

  assign out_last = out_valid
                  & ({1'b0, idx} == nwords_q - 3'd1);
  assign hs       = out_valid & out_ready;
  assign take     = in_valid & ~rst
                  & ((st == IDLE) | (hs & out_last));
  assign in_ack   = take;

  // Word mux; index counts in emission order.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (int'(idx) == i) begin
        if (LSW_FIRST != 0)
          out_data = hold[i*OUT_W +: OUT_W];
        else
          out_data = hold[(RATIO-1-i)*OUT_W +: OUT_W];
      end
    end
  end

  // Beat load / word advance FSM; reload on last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      hold         <= '0;
      idx          <= '0;
      nwords_q     <= '0;
      out_valid    <= 1'b0;
      beats_popped <= '0;
    end else if (take) begin
      st           <= DRAIN;
      hold         <= in_data;
      idx          <= '0;
      nwords_q     <= nwords_decode(in_nwords);
      out_valid    <= 1'b1;
      beats_popped <= beats_popped + 16'd1;
    end else if (hs && out_last) begin
      st        <= IDLE;
      out_valid <= 1'b0;
    end else if (hs) begin
      idx <= idx + 2'd1;
    end
  end

  cr_kme_sticky_err u_ovf (
    .clk (clk),
    .rst (rst),
    .set (fifo_overflow),
    .clr (err_clr),
    .q   (err_ovf)
  );

  cr_kme_sticky_err u_udf (
    .clk (clk),
    .rst (rst),
    .set (fifo_underflow),
    .clr (err_clr),
    .q   (err_udf)
  );

endmodule

// File: doc/cr_kme_fifo_unpack.md
Name: cr_kme_fifo_unpack

Overview:
- Read-side consumer for the KME 128-bit staging FIFO.
- Pops 128-bit beats using the FIFO's valid/ack interface, where ack is used as the read enable. Serializes each beat into 32-bit words on a downstream valid/ready stream.
- Supports partial beats through a word-count sideband.
- Captures the FIFO's overflow/underflow pulses into sticky error flags for the KME status block.

Parameters:
- IN_W, 128, input beat width; must equal RATIO*OUT_W.
- OUT_W, 32, output word width.
- RATIO, 4, words per beat; derived, do not override.
- LSW_FIRST, 1, 1 = word 0 is bits[OUT_W-1:0] and is emitted first; 0 = MSW first.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  IN_W  beat from FIFO read data.
- in_valid  input  1  FIFO not empty.
- in_nwords  input  2  valid words in the beat; 0 encodes RATIO (4).
- in_ack  output  1  pop strobe to FIFO (ren); combinational.
- out_data  output  OUT_W  current word.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts.
- out_last  output  1  last valid word of the current beat.
- fifo_overflow  input  1  pulse from FIFO.
- fifo_underflow  input  1  pulse from FIFO.
- err_clr  input  1  clears sticky errors.
- err_ovf  output  1  sticky overflow.
- err_udf  output  1  sticky underflow.
- beats_popped  output  16  count of beats acknowledged; wraps.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high on `rst`, sampled at the `clk` rising edge.
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, holding register=0, word index=0, `nwords_q`=0, `err_ovf`=0, `err_udf`=0, `beats_popped`=0. While `rst`=1, `in_ack` is forced to 0.
- State machine, 2 states:
  - IDLE: holding register empty.
  - DRAIN: holding register valid.
- Accept condition: `take` = `in_valid` & (state==IDLE | (`out_valid` & `out_ready` & `out_last`)). `in_ack` = `take`. A beat is popped only when `take`=1, never otherwise.
- On `take`:
  - Register `in_data` into the holding register.
  - `nwords_q` = (`in_nwords`==0 ? 4 : `in_nwords`).
  - Word index = 0.
  - Next state = DRAIN.
  - `beats_popped`++ (mod 2^16).
- Latency and throughput:
  - First word of a beat is valid the cycle after `take`.
  - Steady state: one word per cycle.
  - A new beat loads in the same cycle the previous last word handshakes, with no bubble between beats.
- In DRAIN:
  - `out_valid`=1.
  - `out_data` = word[index], with the LSW_FIRST mapping.
  - `out_last` = (index == `nwords_q`-1).
  - On `out_valid` & `out_ready` & !`out_last`: index++.
  - On `out_valid` & `out_ready` & `out_last`: load the next beat if `take`, else go to IDLE.
- Stall: `out_ready`=0 holds `out_data`, `out_valid` and `out_last` stable. `in_ack` stays 0 while any word remains.
- Partial beat: words at index ≥ `nwords_q` are never emitted. `in_nwords`=1 yields a single word with `out_last`=1.
- Sticky error flags:
  - `err_ovf` sets on `fifo_overflow`; `err_udf` sets on `fifo_underflow`.
  - They hold until `err_clr`.
  - If a set and `err_clr` occur in the same cycle, set wins.
- Reset mid-beat: the partially drained beat is discarded and not replayed. The FIFO is reset by the same controller, so data stays consistent.
- `in_data` is sampled only on `take`. Its value while `in_ack`=0 is don't-care.

Decomposition:
- Package `cr_kme_fifo_unpack_pkg`:
  - State enum {IDLE, DRAIN}.
  - Constants KME_BEAT_W=128, KME_WORD_W=32, KME_RATIO=4.
  - Function `nwords_decode(2b) -> 3b`.
- Sub-module `cr_kme_sticky_err`: one instance per flag, with set/clr/q and set-priority.
- Everything else stays inline.

Test Plan:
- Single full beat: `in_data`=128'h00000004_00000003_00000002_00000001, `in_nwords`=0, `out_ready`=1 → `in_ack` pulses 1 cycle. `out_data` is 1, 2, 3, 4 on consecutive cycles. `out_last` is asserted only on word 4. `beats_popped`=1.
- Back-to-back: 3 beats queued, `out_ready`=1 → 12 words in 12 consecutive cycles, no bubble. `in_ack` is asserted in the same cycle as each `out_last` handshake.
- Backpressure: `out_ready` toggles 0/1 each cycle over one beat → each word is held stable while `out_ready`=0. The beat completes in 8 cycles. `in_ack` is not asserted again before the final handshake.
- Partial beats: `in_nwords`=1, then 3 → emits 1 word with `out_last`, then 3 words with `out_last` on the third. Upper words are never seen.
- LSW_FIRST=0: same beat as the first scenario → `out_data` is 4, 3, 2, 1.
- Error and reset:
  - Pulse `fifo_overflow` → `err_ovf`=1 and holds.
  - `err_clr` together with `fifo_underflow` → `err_ovf`=0, `err_udf`=1.
  - Assert `rst` after word 2 of a beat → next cycle `out_valid`=0, `beats_popped`=0, and `in_ack`=0 while `rst` is held.
